commit_walk_eng: RTL
====================

Name: commit_walk_eng

Overview:
- Parametrised successor to the VR commit engine.
- Accepts a decoded commit request (view, commit number) and validates it against the current replica VR state.
- Walks the log-header memory from last_commit+1 up to the target, setting the committed bit in each header by read-modify-write.
- Publishes last_commit progress to the VR state every MAX_BATCH entries, and returns a status/count response to the manager.

Parameters:
- VIEW_W, 32: view number width.
- OP_W, 64: op/commit number width.
- LOG_DEPTH_W, 10: log-header memory address width; memory depth is 2**LOG_DEPTH_W.
- LOG_HDR_W, 128: log-header word width.
- COMMIT_BIT, 0: bit index of the committed flag within the header word.
- MAX_BATCH, 16: entries committed between intermediate state writes; must be >=1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_val  in  1  commit request valid
- req_view  in  VIEW_W  view carried in the request
- req_commit_num  in  OP_W  requested commit number
- req_rdy  out  1  request accepted
- state_view  in  VIEW_W  current VR view (always valid)
- state_last_commit  in  OP_W  current last committed op (always valid)
- state_op_num  in  OP_W  highest logged op (always valid)
- state_wr_val  out  1  last_commit update valid
- state_wr_last_commit  out  OP_W  new last_commit
- state_wr_rdy  in  1  state write accepted
- hdr_rd_req_val  out  1  header read request valid
- hdr_rd_req_addr  out  LOG_DEPTH_W  header read address
- hdr_rd_req_rdy  in  1  header read request accepted
- hdr_rd_resp_val  in  1  header read data valid
- hdr_rd_resp_data  in  LOG_HDR_W  header read data
- hdr_rd_resp_rdy  out  1  header read data consumed
- hdr_wr_val  out  1  header write valid
- hdr_wr_addr  out  LOG_DEPTH_W  header write address
- hdr_wr_data  out  LOG_HDR_W  header write data
- hdr_wr_rdy  in  1  header write accepted
- resp_val  out  1  response valid
- resp_status  out  2  0=OK, 1=STALE_VIEW, 2=NOOP, 3=CLAMPED
- resp_count  out  OP_W  entries committed by this request
- resp_rdy  in  1  response consumed
- eng_rdy  out  1  engine idle

Behaviour:
- Clock/reset: single clock clk; rst is asynchronous, active-high. All registered state clears on rst regardless of clk.
- Reset values: FSM=IDLE, all *_val=0, resp_status=0, resp_count=0, internal counters=0. req_rdy=1 and eng_rdy=1 (combinational, IDLE only).
- Reset mid-walk aborts immediately:
  - no further reads or writes are issued;
  - headers already written stay committed;
  - last_commit keeps only the last accepted state write.
- Handshakes: transfer on val&rdy. Once asserted, a val and its payload are held stable until rdy.
- IDLE:
  - req_rdy=1.
  - On accept, register req_view and req_commit_num, snapshot state_last_commit into cur, and go to CHECK.
- CHECK (1 cycle), evaluated in this order:
  - req_view != state_view -> status STALE_VIEW, count 0, go to RESP.
  - Else target = min(req_commit_num, state_op_num); status = CLAMPED if req_commit_num > state_op_num, else OK.
  - Then if target <= cur -> status NOOP (overrides CLAMPED), count 0, go to RESP.
  - Else go to RD_REQ.
- RD_REQ:
  - hdr_rd_req_val=1, addr = (cur+1)[LOG_DEPTH_W-1:0]; index wrap-around is the natural truncation.
  - On rdy go to RD_RESP.
- RD_RESP:
  - hdr_rd_resp_rdy=1.
  - On val, latch data with bit COMMIT_BIT forced to 1 (all other bits unchanged), then go to WR.
  - Latency of the memory response is unbounded; the engine waits.
- WR:
  - hdr_wr_val=1, same address as the read.
  - On rdy: cur<=cur+1, count<=count+1, batch<=batch+1.
  - If cur+1==target or batch+1==MAX_BATCH, go to ST_WR; else go to RD_REQ.
- ST_WR:
  - state_wr_val=1, state_wr_last_commit=cur.
  - On rdy, batch<=0; if cur==target go to RESP, else go to RD_REQ.
- RESP:
  - resp_val=1 with registered status and count.
  - On resp_rdy, clear count and go to IDLE.
- Throughput: one entry per 3 cycles with always-ready memory.
- At most one outstanding header read; no read is issued before the prior write is accepted.
- Already-committed headers are rewritten unchanged and still counted.
- Arithmetic: cur and count are OP_W-bit unsigned. target <= state_op_num guarantees cur+1 never overflows within a walk.
- State inputs are sampled only in the IDLE accept cycle and in CHECK; changes during a walk are ignored.

Test Plan:
- Basic walk: state view=5, last_commit=9, op_num=20; req view=5, commit=12 -> 3 header reads/writes at addrs 10, 11, 12 with bit0 set; one state write of 12; resp OK, count 3.
- Stale view: state view=5; req view=4 -> no hdr or state traffic; resp STALE_VIEW, count 0.
- Clamp and batching: MAX_BATCH=4, last_commit=0, op_num=10, req commit=50 -> state writes 4, 8, 10; resp CLAMPED, count 10.
- NOOP: last_commit=30, req commit=25 -> resp NOOP, count 0, no writes.
- Wrap and backpressure: LOG_DEPTH_W=4, last_commit=14, req commit=17; random stalls on hdr_rd_req_rdy, hdr_rd_resp_val, hdr_wr_rdy and state_wr_rdy -> addrs 15, 0, 1; payloads stable under stall; resp OK, count 3.
- Async reset mid-walk: assert rst while in WR -> hdr_wr_val drops without a clock edge; after release eng_rdy=1 and the next request executes normally.

Source files
------------

// File: rtl/commit_walk_if.sv
// Bundles the request, VR-state, log-header and response channels of the commit walk engine.
// master = engine side, slave = surrounding manager / memory / VR state.
interface commit_walk_if #(
   parameter int VIEW_W      = 32,
   parameter int OP_W        = 64,
   parameter int LOG_DEPTH_W = 10,
   parameter int LOG_HDR_W   = 128
);
   logic                   req_val;
   logic [VIEW_W-1:0]      req_view;
   logic [OP_W-1:0]        req_commit_num;
   logic                   req_rdy;

   logic [VIEW_W-1:0]      state_view;
   logic [OP_W-1:0]        state_last_commit;
   logic [OP_W-1:0]        state_op_num;
   logic                   state_wr_val;
   logic [OP_W-1:0]        state_wr_last_commit;
   logic                   state_wr_rdy;

   logic                   hdr_rd_req_val;
   logic [LOG_DEPTH_W-1:0] hdr_rd_req_addr;
   logic                   hdr_rd_req_rdy;
   logic                   hdr_rd_resp_val;
   logic [LOG_HDR_W-1:0]   hdr_rd_resp_data;
   logic                   hdr_rd_resp_rdy;
   logic                   hdr_wr_val;
   logic [LOG_DEPTH_W-1:0] hdr_wr_addr;
   logic [LOG_HDR_W-1:0]   hdr_wr_data;
   logic                   hdr_wr_rdy;

   logic                   resp_val;
   logic [1:0]             resp_status;
   logic [OP_W-1:0]        resp_count;
   logic                   resp_rdy;
   logic                   eng_rdy;

   modport master (
      input  req_val, req_view, req_commit_num,
      output req_rdy,
      input  state_view, state_last_commit, state_op_num,
      output state_wr_val, state_wr_last_commit,
      input  state_wr_rdy,
      output hdr_rd_req_val, hdr_rd_req_addr,
      input  hdr_rd_req_rdy,
      input  hdr_rd_resp_val, hdr_rd_resp_data,
      output hdr_rd_resp_rdy,
      output hdr_wr_val, hdr_wr_addr, hdr_wr_data,
      input  hdr_wr_rdy,
      output resp_val, resp_status, resp_count,
      input  resp_rdy,
      output eng_rdy
   );

   modport slave (
      output req_val, req_view, req_commit_num,
      input  req_rdy,
      output state_view, state_last_commit, state_op_num,
      input  state_wr_val, state_wr_last_commit,
      output state_wr_rdy,
      input  hdr_rd_req_val, hdr_rd_req_addr,
      output hdr_rd_req_rdy,
      output hdr_rd_resp_val, hdr_rd_resp_data,
      input  hdr_rd_resp_rdy,
      input  hdr_wr_val, hdr_wr_addr, hdr_wr_data,
      output hdr_wr_rdy,
      input  resp_val, resp_status, resp_count,
      output resp_rdy,
      input  eng_rdy
   );
endinterface

// File: rtl/commit_walk_eng.sv
// VR commit engine: validates a commit request, then walks the log headers from
// last_commit+1 to the target setting the committed bit, publishing progress in batches.
module commit_walk_eng #(
   parameter int VIEW_W      = 32,
   parameter int OP_W        = 64,
   parameter int LOG_DEPTH_W = 10,
   parameter int LOG_HDR_W   = 128,
   parameter int COMMIT_BIT  = 0,
   parameter int MAX_BATCH   = 16
) (
   input logic            clk,
   input logic            rst,
   commit_walk_if.master  bus
);
   localparam int BATCH_W = $clog2(MAX_BATCH + 1);

   localparam logic [1:0] ST_OK      = 2'd0;
   localparam logic [1:0] ST_STALE   = 2'd1;
   localparam logic [1:0] ST_NOOP    = 2'd2;
   localparam logic [1:0] ST_CLAMPED = 2'd3;

   typedef enum logic [2:0] {IDLE, CHECK, RD_REQ, RD_RESP, WR, ST_WR, RESP} state_t;

   state_t               state_reg,  state_next;
   logic [VIEW_W-1:0]    view_reg,   view_next;
   logic [OP_W-1:0]      commit_reg, commit_next;
   logic [OP_W-1:0]      cur_reg,    cur_next;
   logic [OP_W-1:0]      target_reg, target_next;
   logic [OP_W-1:0]      count_reg,  count_next;
   logic [BATCH_W-1:0]   batch_reg,  batch_next;
   logic [1:0]           status_reg, status_next;
   logic [LOG_HDR_W-1:0] data_reg,   data_next;

   logic [OP_W-1:0]      cur_inc;
   logic [BATCH_W-1:0]   batch_inc;
   logic                 clamp;
   logic [OP_W-1:0]      clamp_target;

   assign cur_inc      = cur_reg + OP_W'(1);
   assign batch_inc    = batch_reg + BATCH_W'(1);
   assign clamp        = commit_reg > bus.state_op_num;
   assign clamp_target = clamp ? bus.state_op_num : commit_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg  <= IDLE;
         view_reg   <= '0;
         commit_reg <= '0;
         cur_reg    <= '0;
         target_reg <= '0;
         count_reg  <= '0;
         batch_reg  <= '0;
         status_reg <= ST_OK;
         data_reg   <= '0;
      end else begin
         state_reg  <= state_next;
         view_reg   <= view_next;
         commit_reg <= commit_next;
         cur_reg    <= cur_next;
         target_reg <= target_next;
         count_reg  <= count_next;
         batch_reg  <= batch_next;
         status_reg <= status_next;
         data_reg   <= data_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      view_next   = view_reg;
      commit_next = commit_reg;
      cur_next    = cur_reg;
      target_next = target_reg;
      count_next  = count_reg;
      batch_next  = batch_reg;
      status_next = status_reg;
      data_next   = data_reg;
      case (state_reg)
         IDLE: begin
            if (bus.req_val) begin
               view_next   = bus.req_view;
               commit_next = bus.req_commit_num;
               cur_next    = bus.state_last_commit;
               count_next  = '0;
               batch_next  = '0;
               state_next  = CHECK;
            end
         end
         CHECK: begin
            if (view_reg != bus.state_view) begin
               status_next = ST_STALE;
               state_next  = RESP;
            end else begin
               target_next = clamp_target;
               // NOOP wins over CLAMPED when there is nothing left to commit
               if (clamp_target <= cur_reg) begin
                  status_next = ST_NOOP;
                  state_next  = RESP;
               end else begin
                  status_next = clamp ? ST_CLAMPED : ST_OK;
                  state_next  = RD_REQ;
               end
            end
         end
         RD_REQ: begin
            if (bus.hdr_rd_req_rdy) state_next = RD_RESP;
         end
         RD_RESP: begin
            if (bus.hdr_rd_resp_val) begin
               data_next             = bus.hdr_rd_resp_data;
               data_next[COMMIT_BIT] = 1'b1;
               state_next            = WR;
            end
         end
         WR: begin
            if (bus.hdr_wr_rdy) begin
               cur_next   = cur_inc;
               count_next = count_reg + OP_W'(1);
               batch_next = batch_inc;
               if (cur_inc == target_reg || batch_inc == BATCH_W'(MAX_BATCH))
                  state_next = ST_WR;
               else
                  state_next = RD_REQ;
            end
         end
         ST_WR: begin
            if (bus.state_wr_rdy) begin
               batch_next = '0;
               state_next = (cur_reg == target_reg) ? RESP : RD_REQ;
            end
         end
         RESP: begin
            if (bus.resp_rdy) begin
               count_next = '0;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Read and write share the address: cur only advances once the write is accepted.
   assign bus.req_rdy              = (state_reg == IDLE);
   assign bus.eng_rdy              = (state_reg == IDLE);
   assign bus.hdr_rd_req_val       = (state_reg == RD_REQ);
   assign bus.hdr_rd_req_addr      = cur_inc[LOG_DEPTH_W-1:0];
   assign bus.hdr_rd_resp_rdy      = (state_reg == RD_RESP);
   assign bus.hdr_wr_val           = (state_reg == WR);
   assign bus.hdr_wr_addr          = cur_inc[LOG_DEPTH_W-1:0];
   assign bus.hdr_wr_data          = data_reg;
   assign bus.state_wr_val         = (state_reg == ST_WR);
   assign bus.state_wr_last_commit = cur_reg;
   assign bus.resp_val             = (state_reg == RESP);
   assign bus.resp_status          = status_reg;
   assign bus.resp_count           = count_reg;
endmodule
